// File: rtl/foo_pkg.sv
// Shared definitions for the foo datapath multiplier sharing logic.
package foo_pkg;
   localparam int FOO_DATA_W  = 32;
   localparam int FOO_MUL_LAT = 2;

   // Requester indices: t5 product (a+4)*(b+7) and t10 square t9*t9
   localparam int REQ_T5  = 0;
   localparam int REQ_T10 = 1;

   // Tag travelling alongside each multiply so the result finds its issuer
   typedef struct packed {
      logic vld;
      logic id;
   } mul_tag_t;
endpackage

// File: rtl/foo_mul_pipe.sv
// Pipelined unsigned multiplier, low DATA_W bits of the product.
// Data registers carry no reset; validity is tracked by the caller's tags.
module foo_mul_pipe
   import foo_pkg::*;
#(
   parameter int DATA_W  = FOO_DATA_W,
   parameter int MUL_LAT = FOO_MUL_LAT
) (
   input  logic              clk,
   input  logic [DATA_W-1:0] mul_a,
   input  logic [DATA_W-1:0] mul_b,
   output logic [DATA_W-1:0] mul_p
);

   logic [DATA_W-1:0] stage_d [MUL_LAT];
   logic [DATA_W-1:0] stage_q [MUL_LAT];

   // First stage forms the truncated product, later stages just delay it
   always_comb begin
      stage_d[0] = mul_a * mul_b;
      for (int k = 1; k < MUL_LAT; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   // Stage registers
   always_ff @(posedge clk) begin
      for (int k = 0; k < MUL_LAT; k++) begin
         stage_q[k] <= stage_d[k];
      end
   end

   assign mul_p = stage_q[MUL_LAT-1];

endmodule

// File: rtl/foo_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between the t5 and
// t10 multiply stages. A {vld,id} tag shift register runs beside the
// multiplier and routes each product back to its issuer.
// Optional: define FOO_MUL_ARB_PERF_EN to add saturating grant/conflict
// counters.
module foo_mul_arbiter
   import foo_pkg::*;
#(
   parameter int DATA_W  = FOO_DATA_W,
   parameter int MUL_LAT = FOO_MUL_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
`ifdef FOO_MUL_ARB_PERF_EN
   ,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1,
   output logic [15:0]       conflict_cnt
`endif
);

   logic              prio_d, prio_q;
   logic [1:0]        accept;
   logic              any_acc;
   logic              gnt_id;
   logic [DATA_W-1:0] mul_a, mul_b, mul_p;
   mul_tag_t          tag_d [MUL_LAT];
   mul_tag_t          tag_q [MUL_LAT];
   mul_tag_t          tag_out;
   logic [DATA_W-1:0] rsp_data_d, rsp_data_q;

   // Grant: flush blocks everything, a lone requester wins, a tie goes to prio
   always_comb begin
      req_ready = 2'b00;
      if (!flush) begin
         if (req_valid == 2'b11) begin
            req_ready[prio_q] = 1'b1;
         end else begin
            req_ready = req_valid;
         end
      end
   end

   assign accept  = req_valid & req_ready;
   assign any_acc = |accept;
   assign gnt_id  = accept[REQ_T10];
   assign mul_a   = gnt_id ? req_a1 : req_a0;
   assign mul_b   = gnt_id ? req_b1 : req_b0;

   // Priority passes to the requester that was not served
   always_comb begin
      prio_d = prio_q;
      if (any_acc) begin
         prio_d = ~gnt_id;
      end
   end

   foo_mul_pipe #(
      .DATA_W  (DATA_W),
      .MUL_LAT (MUL_LAT)
   ) u_mul_pipe (
      .clk   (clk),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .mul_p (mul_p)
   );

   // Tag shift register; flush invalidates every in-flight tag
   always_comb begin
      tag_d[0].vld = any_acc;
      tag_d[0].id  = gnt_id;
      for (int k = 1; k < MUL_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end
      if (flush) begin
         for (int k = 0; k < MUL_LAT; k++) begin
            tag_d[k].vld = 1'b0;
         end
      end
   end

   assign tag_out = tag_q[MUL_LAT-1];

   // Result data shows the live product on a pulse and otherwise holds
   always_comb begin
      rsp_data_d = tag_out.vld ? mul_p : rsp_data_q;
   end

   // Arbiter, tag and response-hold state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= 1'b0;
         rsp_data_q <= '0;
         for (int k = 0; k < MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         prio_q     <= prio_d;
         rsp_data_q <= rsp_data_d;
         for (int k = 0; k < MUL_LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
      end
   end

   // Response steering and busy indication
   always_comb begin
      rsp_valid = 2'b00;
      if (tag_out.vld) begin
         rsp_valid[tag_out.id] = 1'b1;
      end
      busy = 1'b0;
      for (int k = 0; k < MUL_LAT; k++) begin
         busy = busy | tag_q[k].vld;
      end
   end

   assign rsp_data = rsp_data_d;

`ifdef FOO_MUL_ARB_PERF_EN
   logic [15:0] grant_cnt0_d, grant_cnt0_q;
   logic [15:0] grant_cnt1_d, grant_cnt1_q;
   logic [15:0] conflict_cnt_d, conflict_cnt_q;

   // Saturating event counters, cleared by flush
   always_comb begin
      grant_cnt0_d   = grant_cnt0_q;
      grant_cnt1_d   = grant_cnt1_q;
      conflict_cnt_d = conflict_cnt_q;
      if (flush) begin
         grant_cnt0_d   = '0;
         grant_cnt1_d   = '0;
         conflict_cnt_d = '0;
      end else begin
         if (accept[REQ_T5] && grant_cnt0_q != 16'hFFFF) begin
            grant_cnt0_d = grant_cnt0_q + 16'd1;
         end
         if (accept[REQ_T10] && grant_cnt1_q != 16'hFFFF) begin
            grant_cnt1_d = grant_cnt1_q + 16'd1;
         end
         if (req_valid == 2'b11 && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt0_q   <= grant_cnt0_d;
         grant_cnt1_q   <= grant_cnt1_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign grant_cnt0   = grant_cnt0_q;
   assign grant_cnt1   = grant_cnt1_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_foo_mul_arbiter.sv
// Scoreboard bench for foo_mul_arbiter: the driver predicts grants and
// products from the arbitration rules and queues expected responses; an
// independent monitor pops and compares whenever the DUT presents a result.
module tb_foo_mul_arbiter;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [1:0]    req_ready;
   logic [DW-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [1:0]    rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          busy;
`ifdef FOO_MUL_ARB_PERF_EN
   logic [15:0]   grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   foo_mul_arbiter #(.DATA_W(DW), .MUL_LAT(LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
`ifdef FOO_MUL_ARB_PERF_EN
      ,
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1),
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic          m_prio = 1'b0;
   logic [1:0]    m_acc;
   logic [DW-1:0] m_last = '0;
   int            m_g0 = 0, m_g1 = 0, m_cf = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] full;
      full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return full[DW-1:0];
   endfunction

   // Which requester the rules say should be served this cycle
   function automatic logic [1:0] exp_ready();
      if (flush) return 2'b00;
      if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
      return req_valid;
   endfunction

   // One clock cycle with the currently driven inputs
   task automatic go();
      exp_t e;
      logic [1:0] r;
      @(negedge clk);
      r = exp_ready();
      chk("req_ready", {62'd0, req_ready}, {62'd0, r});
`ifdef FOO_MUL_ARB_PERF_EN
      chk("grant_cnt0", {48'd0, grant_cnt0}, 64'(m_g0));
      chk("grant_cnt1", {48'd0, grant_cnt1}, 64'(m_g1));
      chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cf));
`endif
      @(posedge clk);
      m_acc = req_valid & r;
      if (flush) begin
         sb.delete();
         m_g0 = 0; m_g1 = 0; m_cf = 0;
      end else begin
         if (req_valid == 2'b11 && m_cf < 65535) m_cf++;
      end
      if (m_acc != 2'b00) begin
         e.id   = m_acc[1];
         e.data = m_acc[1] ? prod(req_a1, req_b1) : prod(req_a0, req_b0);
         e.due  = cyc + LAT;
         sb.push_back(e);
         m_prio = ~m_acc[1];
         if (m_acc[0] && m_g0 < 65535) m_g0++;
         if (m_acc[1] && m_g1 < 65535) m_g1++;
      end
      cyc++;
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [DW-1:0] a1, input logic [DW-1:0] b1);
      req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
   endtask

   task automatic idle(input int n);
      req_valid = 2'b00;
      flush = 1'b0;
      for (int i = 0; i < n; i++) go();
   endtask

   // Asynchronous reset pulse in the middle of a cycle
   task automatic mid_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      sb.delete();
      m_prio = 1'b0; m_last = '0;
      m_g0 = 0; m_g1 = 0; m_cf = 0;
`ifdef FOO_MUL_ARB_PERF_EN
      chk("rst_grant_cnt0", {48'd0, grant_cnt0}, 64'd0);
      chk("rst_conflict_cnt", {48'd0, conflict_cnt}, 64'd0);
`endif
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("busy", {63'd0, busy}, {63'd0, (sb.size() != 0)});
            if (rsp_valid != 2'b00) begin
               if (sb.size() == 0) begin
                  chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", {62'd0, rsp_valid}, e.id ? 64'd2 : 64'd1);
                  chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                  chk("rsp_cycle", 64'(cyc), 64'(e.due));
                  m_last = e.data;
               end
            end else begin
               if (sb.size() != 0 && sb[0].due <= cyc) begin
                  e = sb.pop_front();
                  chk("rsp_missing", {62'd0, rsp_valid}, e.id ? 64'd2 : 64'd1);
               end
               chk("rsp_hold", {32'd0, rsp_data}, {32'd0, m_last});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Stimulus
   initial begin
      logic [1:0] hold;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      idle(1);

      // Single requests on each side
      set_req(2'b01, 32'd5, 32'd9, 32'd0, 32'd0); go();
      idle(3);
      chk("t5_result", {32'd0, rsp_data}, 64'd45);
      set_req(2'b10, 32'd0, 32'd0, 32'd135, 32'd135); go();
      idle(3);
      chk("t10_result", {32'd0, rsp_data}, 64'd18225);

      // Both valid: alternating grants, back-to-back responses
      set_req(2'b11, 32'd5, 32'd9, 32'd135, 32'd135);
      repeat (4) go();
      idle(3);

      // Truncation
      set_req(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0); go();
      set_req(2'b01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0); go();
      idle(1);
      chk("ovf_result", {32'd0, rsp_data}, 64'hFFFF_FFFE);
      idle(2);

      // Flush kills the in-flight op and blocks the same-cycle request
      set_req(2'b01, 32'd7, 32'd3, 32'd0, 32'd0); go();
      flush = 1'b1; go();
      idle(4);

      // Reset while two ops are in flight, then conflict cycles
      set_req(2'b01, 32'd11, 32'd13, 32'd0, 32'd0); go();
      set_req(2'b10, 32'd0, 32'd0, 32'd17, 32'd19); go();
      req_valid = 2'b00;
      mid_reset();
      idle(4);
      set_req(2'b11, 32'd2, 32'd3, 32'd4, 32'd5);
      repeat (3) go();
      idle(3);

      // Randomized traffic; a losing requester keeps its request stable
      m_acc = 2'b00;
      req_valid = 2'b00;
      for (int i = 0; i < 600; i++) begin
         hold = req_valid & ~m_acc;
         if (!hold[0]) begin
            req_valid[0] = ($urandom_range(0, 9) < 7);
            req_a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_b0 = $urandom_range(0, 3) == 0 ? 32'(($urandom_range(0, 255))) : $urandom;
         end
         if (!hold[1]) begin
            req_valid[1] = ($urandom_range(0, 9) < 7);
            req_a1 = $urandom;
            req_b1 = req_a1;
         end
         flush = ($urandom_range(0, 15) == 0);
         if (i == 300) begin
            mid_reset();
            m_acc = 2'b00;
         end
         go();
      end
      idle(LAT + 2);
      chk("drain_empty", {63'd0, busy}, {63'd0, (sb.size() != 0)});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
